// File: rtl/usb_ahb_data_buffer_if.sv
// Byte-buffer bus between the USB RX/TX engines, the AHB store/get port and the buffer.
// Watermark signals exist only when USB_AHB_BUF_WATERMARK_EN is defined.
interface usb_ahb_data_buffer_if #(
  parameter int DEPTH = 64
);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic             clear;
  logic             rx_push;
  logic [7:0]       rx_data;
  logic             tx_pop;
  logic [7:0]       tx_data;
  logic             store_en;
  logic [1:0]       store_size;
  logic [31:0]      store_data;
  logic             get_en;
  logic [1:0]       get_size;
  logic [31:0]      get_data;
  logic [CNT_W-1:0] occupancy;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;
  logic             conflict;
`ifdef USB_AHB_BUF_WATERMARK_EN
  logic             almost_full;
  logic             almost_empty;
`endif

  modport slave (
    input  clear, rx_push, rx_data, tx_pop, store_en, store_size, store_data,
           get_en, get_size,
    output tx_data, get_data, occupancy, empty, full, overflow, underflow,
`ifdef USB_AHB_BUF_WATERMARK_EN
           almost_full, almost_empty,
`endif
           conflict
  );

  modport master (
    output clear, rx_push, rx_data, tx_pop, store_en, store_size, store_data,
           get_en, get_size,
    input  tx_data, get_data, occupancy, empty, full, overflow, underflow,
`ifdef USB_AHB_BUF_WATERMARK_EN
           almost_full, almost_empty,
`endif
           conflict
  );
endinterface

// File: rtl/usb_ahb_data_buffer.sv
// Shared byte buffer: USB pushes/pops bytes, AHB stores/gets 1/2/4-byte LE words (get_data 1 cycle).
// Whole-access admission, sticky error flags; USB_AHB_BUF_WATERMARK_EN adds almost_full/almost_empty.
module usb_ahb_data_buffer #(
  parameter  int DEPTH = 64,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  usb_ahb_data_buffer_if.slave  bus
);

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CNT_W-1:0] occ_q, occ_d;
  logic [31:0]      get_data_q, get_data_d;
  logic             ovf_q, ovf_d, udf_q, udf_d, cfl_q, cfl_d;

  logic [2:0]       wr_n, rd_n;
  logic             wr_ok, rd_ok;
  logic [31:0]      wr_word, rd_word;
  logic [CNT_W-1:0] free;

  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      2'd0:    return 3'd1;
      2'd1:    return 3'd2;
      2'd2:    return 3'd4;
      default: return 3'd0;
    endcase
  endfunction

  always_comb begin
    free    = CNT_W'(DEPTH) - occ_q;
    wr_n    = 3'd0;
    wr_ok   = 1'b0;
    wr_word = 32'd0;
    rd_n    = 3'd0;
    rd_ok   = 1'b0;
    rd_word = 32'd0;
    ovf_d   = ovf_q;
    udf_d   = udf_q;
    cfl_d   = cfl_q;

    // RX byte always wins the write side; a colliding store is dropped
    if (bus.rx_push) begin
      wr_n    = 3'd1;
      wr_word = {24'd0, bus.rx_data};
      wr_ok   = free >= CNT_W'(1);
      if (bus.store_en) cfl_d = 1'b1;
    end else if (bus.store_en) begin
      wr_n    = size_bytes(bus.store_size);
      wr_word = bus.store_data;
      wr_ok   = (wr_n != 3'd0) && (free >= CNT_W'(wr_n));
    end
    if ((bus.rx_push || bus.store_en) && !wr_ok) ovf_d = 1'b1;

    if (bus.tx_pop) begin
      rd_n  = 3'd1;
      rd_ok = occ_q >= CNT_W'(1);
      if (bus.get_en) cfl_d = 1'b1;
    end else if (bus.get_en) begin
      rd_n  = size_bytes(bus.get_size);
      rd_ok = (rd_n != 3'd0) && (occ_q >= CNT_W'(rd_n));
    end
    if ((bus.tx_pop || bus.get_en) && !rd_ok) udf_d = 1'b1;

    for (int k = 0; k < 4; k++) begin
      if (3'(k) < rd_n) rd_word[8*k +: 8] = mem[rptr_q + PTR_W'(k)];
    end

    get_data_d = get_data_q;
    if (bus.get_en && !bus.tx_pop) get_data_d = rd_ok ? rd_word : 32'd0;

    wptr_d = wr_ok ? wptr_q + PTR_W'(wr_n) : wptr_q;
    rptr_d = rd_ok ? rptr_q + PTR_W'(rd_n) : rptr_q;
    occ_d  = occ_q + (wr_ok ? CNT_W'(wr_n) : CNT_W'(0))
                   - (rd_ok ? CNT_W'(rd_n) : CNT_W'(0));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.clear) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      occ_q      <= '0;
      get_data_q <= '0;
      ovf_q      <= 1'b0;
      udf_q      <= 1'b0;
      cfl_q      <= 1'b0;
    end else begin
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      occ_q      <= occ_d;
      get_data_q <= get_data_d;
      ovf_q      <= ovf_d;
      udf_q      <= udf_d;
      cfl_q      <= cfl_d;
    end
  end

  // Storage is not reset; pointers and occupancy define what is valid
  always_ff @(posedge clk_i) begin
    if (wr_ok && !rst_i && !bus.clear) begin
      for (int k = 0; k < 4; k++) begin
        if (3'(k) < wr_n) mem[wptr_q + PTR_W'(k)] <= wr_word[8*k +: 8];
      end
    end
  end

  assign bus.tx_data   = mem[rptr_q];
  assign bus.get_data  = get_data_q;
  assign bus.occupancy = occ_q;
  assign bus.empty     = (occ_q == '0);
  assign bus.full      = (occ_q == CNT_W'(DEPTH));
  assign bus.overflow  = ovf_q;
  assign bus.underflow = udf_q;
  assign bus.conflict  = cfl_q;

`ifdef USB_AHB_BUF_WATERMARK_EN
  assign bus.almost_full  = (occ_q >= CNT_W'(DEPTH - 4));
  assign bus.almost_empty = (occ_q < CNT_W'(4));
`endif

endmodule

// File: tb/tb_usb_ahb_data_buffer.sv
// Directed bench for usb_ahb_data_buffer (DEPTH=64) with hand-computed expectations.
module tb_usb_ahb_data_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_run  = 0;
  int   n_fail = 0;

  usb_ahb_data_buffer_if #(.DEPTH(64)) bus ();
  usb_ahb_data_buffer #(.DEPTH(64)) dut (.clk_i(clk), .rst_i(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_run++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic idle();
    bus.clear = 0; bus.rx_push = 0; bus.rx_data = 0; bus.tx_pop = 0;
    bus.store_en = 0; bus.store_size = 0; bus.store_data = 0;
    bus.get_en = 0; bus.get_size = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic do_reset();
    rst = 1; tick(); rst = 0;
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_push = 1; bus.rx_data = b; tick();
  endtask

  task automatic store(input logic [1:0] sz, input logic [31:0] d);
    bus.store_en = 1; bus.store_size = sz; bus.store_data = d; tick();
  endtask

  task automatic get(input logic [1:0] sz);
    bus.get_en = 1; bus.get_size = sz; tick();
  endtask

  task automatic pop();
    bus.tx_pop = 1; tick();
  endtask

  initial begin
    idle();
    do_reset();
    check("rst_empty", 32'(bus.empty), 1);
    check("rst_full", 32'(bus.full), 0);
    check("rst_occ", 32'(bus.occupancy), 0);
    check("rst_get_data", bus.get_data, 0);
    check("rst_flags", {29'd0, bus.overflow, bus.underflow, bus.conflict}, 0);
`ifdef USB_AHB_BUF_WATERMARK_EN
    check("rst_almost_full", 32'(bus.almost_full), 0);
    check("rst_almost_empty", 32'(bus.almost_empty), 1);
`endif

    // Five RX bytes then a word get
    push(8'h11); push(8'h22); push(8'h33); push(8'h44); push(8'h55);
    check("five_occ", 32'(bus.occupancy), 5);
    get(2'd2);
    check("get_word", bus.get_data, 32'h4433_2211);
    check("get_word_occ", 32'(bus.occupancy), 1);
    check("get_word_tx", 32'(bus.tx_data), 32'h55);
    check("get_data_holds", bus.get_data, 32'h4433_2211);

    // Fill with 16 words
    do_reset();
    for (int i = 0; i < 16; i++)
      store(2'd2, {8'(4*i+3), 8'(4*i+2), 8'(4*i+1), 8'(4*i)});
    check("fill_full", 32'(bus.full), 1);
    check("fill_occ", 32'(bus.occupancy), 64);
    check("fill_head", 32'(bus.tx_data), 32'h00);
    check("fill_no_ovf", 32'(bus.overflow), 0);
`ifdef USB_AHB_BUF_WATERMARK_EN
    check("fill_almost_full", 32'(bus.almost_full), 1);
`endif
    push(8'hEE);
    check("ovf_flag", 32'(bus.overflow), 1);
    check("ovf_occ", 32'(bus.occupancy), 64);
    get(2'd1);
    check("get_half_after_fill", bus.get_data, 32'h0000_0100);
    check("ovf_sticky", 32'(bus.overflow), 1);

    // Underflow on empty
    do_reset();
    push(8'hA5);
    get(2'd0);
    check("get_byte", bus.get_data, 32'h0000_00A5);
    get(2'd0);
    check("udf_get_data", bus.get_data, 0);
    check("udf_flag", 32'(bus.underflow), 1);
    check("udf_occ", 32'(bus.occupancy), 0);
    bus.clear = 1; tick();
    check("clear_udf", 32'(bus.underflow), 0);

    // Wrap-around word store at pointer 62
    do_reset();
    for (int i = 0; i < 62; i++) push(8'(i));
    for (int i = 0; i < 62; i++) pop();
    check("wrap_pre_empty", 32'(bus.empty), 1);
    store(2'd2, 32'hDDCC_BBAA);
    check("wrap_occ", 32'(bus.occupancy), 4);
    begin
      logic [31:0] exp_w;
      exp_w = 32'hDDCC_BBAA;
      for (int k = 0; k < 4; k++) begin
        check($sformatf("wrap_tx%0d", k), 32'(bus.tx_data), 32'(exp_w[8*k +: 8]));
        pop();
      end
    end
    check("wrap_empty", 32'(bus.empty), 1);

    // Same-direction collision, then mixed write+read
    do_reset();
    bus.rx_push = 1; bus.rx_data = 8'h7E;
    bus.store_en = 1; bus.store_size = 2'd0; bus.store_data = 32'h99;
    tick();
    check("cfl_flag", 32'(bus.conflict), 1);
    check("cfl_occ", 32'(bus.occupancy), 1);
    check("cfl_head", 32'(bus.tx_data), 32'h7E);
    check("cfl_no_ovf", 32'(bus.overflow), 0);
    push(8'h01); push(8'h02);
    bus.store_en = 1; bus.store_size = 2'd2; bus.store_data = 32'h0403_0201;
    bus.get_en = 1; bus.get_size = 2'd0;
    tick();
    check("mix_occ", 32'(bus.occupancy), 6);
    check("mix_get", bus.get_data, 32'h0000_007E);
    store(2'd3, 32'hFFFF_FFFF);
    check("illegal_store_ovf", 32'(bus.overflow), 1);
    check("illegal_store_occ", 32'(bus.occupancy), 6);
    get(2'd3);
    check("illegal_get_udf", 32'(bus.underflow), 1);
    check("illegal_get_data", bus.get_data, 0);

    // Reset mid-operation
    do_reset();
    for (int i = 0; i < 10; i++) push(8'(8'h30 + i));
    get(2'd0);
    check("pre_rst_get", bus.get_data, 32'h30);
    store(2'd3, 0);
    check("pre_rst_ovf", 32'(bus.overflow), 1);
    rst = 1; bus.get_en = 1; bus.get_size = 2'd1; tick(); rst = 0;
    check("mid_rst_occ", 32'(bus.occupancy), 0);
    check("mid_rst_empty", 32'(bus.empty), 1);
    check("mid_rst_get_data", bus.get_data, 0);
    check("mid_rst_flags", {29'd0, bus.overflow, bus.underflow, bus.conflict}, 0);
`ifdef USB_AHB_BUF_WATERMARK_EN
    check("mid_rst_almost_empty", 32'(bus.almost_empty), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
